// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, holds back the FCS through a 5-byte delay line,
// checks CRC-32, length and error symbols, and streams payload bytes with end-of-frame status.
module gmii_rx_deframer #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1522
) (
  input  logic        gmii_rx_clk,
  input  logic        gmii_rx_rstn,
  input  logic [7:0]  gmii_rx_rxd_i,
  input  logic        gmii_rx_rx_dv_i,
  input  logic        gmii_rx_rx_er_i,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  output logic        rx_good,
  output logic [31:0] cnt_good,
  output logic [31:0] cnt_bad,
  output logic [31:0] cnt_drop
);

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_sr [5];
  logic [2:0]  r_occ;
  logic [10:0] r_len;
  logic [31:0] r_crc;
  logic        r_err;

  logic w_full;
  logic w_goodFrame;
  logic w_startFrame;
  logic w_shift;
  logic w_emit;
  logic w_emitLast;
  logic w_emitGood;
  logic w_incGood;
  logic w_incBad;
  logic w_incDrop;

  function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  assign w_full      = (r_occ == 3'd5);
  assign w_goodFrame = (r_crc == CRC_RESIDUE) && !r_err && (r_len >= MIN_LEN);

  always_ff @(posedge gmii_rx_clk) begin
    if (!gmii_rx_rstn) r_state <= S_DROP;
    else               r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    w_startFrame = 1'b0;
    w_shift      = 1'b0;
    w_emit       = 1'b0;
    w_emitLast   = 1'b0;
    w_emitGood   = 1'b0;
    w_incGood    = 1'b0;
    w_incBad     = 1'b0;
    w_incDrop    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (gmii_rx_rx_dv_i) begin
          if (gmii_rx_rxd_i == 8'h55) begin
            w_nextState = S_PRE;
          end else if (gmii_rx_rxd_i == 8'hD5) begin
            w_nextState  = S_DATA;
            w_startFrame = 1'b1;
          end else begin
            w_nextState = S_DROP;
            w_incDrop   = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (!gmii_rx_rx_dv_i) begin
          w_nextState = S_IDLE;
          w_incDrop   = 1'b1;
        end else if (gmii_rx_rxd_i == 8'hD5) begin
          w_nextState  = S_DATA;
          w_startFrame = 1'b1;
        end else if (gmii_rx_rxd_i != 8'h55) begin
          w_nextState = S_DROP;
          w_incDrop   = 1'b1;
        end
      end
      S_DATA: begin
        if (!gmii_rx_rx_dv_i) begin
          w_nextState = S_IDLE;
          if (w_full) begin
            w_emit     = 1'b1;
            w_emitLast = 1'b1;
            w_emitGood = w_goodFrame;
            w_incGood  = w_goodFrame;
            w_incBad   = !w_goodFrame;
          end else begin
            w_incDrop = 1'b1;
          end
        end else if (r_len == MAX_LEN) begin
          // This byte would exceed the maximum: close out what was delivered and discard the rest
          w_nextState = S_DROP;
          w_incDrop   = 1'b1;
          w_emit      = w_full;
          w_emitLast  = 1'b1;
        end else begin
          w_shift = 1'b1;
          w_emit  = w_full;
        end
      end
      S_DROP: begin
        if (!gmii_rx_rx_dv_i) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (w_shift) begin
      r_sr[0] <= gmii_rx_rxd_i;
      for (int i = 1; i < 5; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!gmii_rx_rstn) begin
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      rx_last  <= 1'b0;
      rx_good  <= 1'b0;
      cnt_good <= 32'd0;
      cnt_bad  <= 32'd0;
      cnt_drop <= 32'd0;
      r_occ    <= 3'd0;
      r_len    <= 11'd0;
      r_crc    <= 32'hFFFFFFFF;
      r_err    <= 1'b0;
    end else begin
      rx_valid <= w_emit;
      rx_last  <= w_emit & w_emitLast;
      rx_good  <= w_emit & w_emitGood;
      if (w_emit) rx_data <= r_sr[4];
      if (w_startFrame) begin
        r_occ <= 3'd0;
        r_len <= 11'd0;
        r_crc <= 32'hFFFFFFFF;
        r_err <= 1'b0;
      end else if (w_shift) begin
        r_len <= r_len + 11'd1;
        r_crc <= crcByte(r_crc, gmii_rx_rxd_i);
        r_err <= r_err | gmii_rx_rx_er_i;
        if (!w_full) r_occ <= r_occ + 3'd1;
      end
      if (w_incGood) cnt_good <= cnt_good + 32'd1;
      if (w_incBad)  cnt_bad  <= cnt_bad + 32'd1;
      if (w_incDrop) cnt_drop <= cnt_drop + 32'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Scoreboard bench for gmii_rx_deframer: two instances (MIN_FRAME=13 and default 64) share one
// GMII stimulus stream; expected payload bytes are queued per instance and popped as they emerge.
module tb_gmii_rx_deframer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       good;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rxd;
  logic       dv;
  logic       er;

  logic [7:0]  sData, dData;
  logic        sValid, sLast, sGood, dValid, dLast, dGood;
  logic [31:0] sCntGood, sCntBad, sCntDrop, dCntGood, dCntBad, dCntDrop;

  exp_t       qShort[$];
  exp_t       qStd[$];
  logic [7:0] frame[$];

  int totalChecks = 0;
  int badChecks = 0;
  int expGoodS = 0, expBadS = 0, expDropS = 0;
  int expGoodD = 0, expBadD = 0, expDropD = 0;

  always #5 clk = ~clk;

  gmii_rx_deframer #(.MIN_FRAME(13)) dutShort (
    .gmii_rx_clk(clk), .gmii_rx_rstn(rstn), .gmii_rx_rxd_i(rxd),
    .gmii_rx_rx_dv_i(dv), .gmii_rx_rx_er_i(er),
    .rx_data(sData), .rx_valid(sValid), .rx_last(sLast), .rx_good(sGood),
    .cnt_good(sCntGood), .cnt_bad(sCntBad), .cnt_drop(sCntDrop)
  );

  gmii_rx_deframer dutStd (
    .gmii_rx_clk(clk), .gmii_rx_rstn(rstn), .gmii_rx_rxd_i(rxd),
    .gmii_rx_rx_dv_i(dv), .gmii_rx_rx_er_i(er),
    .rx_data(dData), .rx_valid(dValid), .rx_last(dLast), .rx_good(dGood),
    .cnt_good(dCntGood), .cnt_bad(dCntBad), .cnt_drop(dCntDrop)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Each instance's output stream is matched against its own expected queue
  always @(negedge clk) begin
    exp_t e;
    if (sValid === 1'b1) begin
      if (qShort.size() == 0) begin
        checkOutput("short stray byte, queue size", 32'(qShort.size()), 32'd1);
      end else begin
        e = qShort.pop_front();
        checkOutput("short data", {24'd0, sData}, {24'd0, e.data});
        checkOutput("short last", {31'd0, sLast}, {31'd0, e.last});
        if (e.last) checkOutput("short good", {31'd0, sGood}, {31'd0, e.good});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (dValid === 1'b1) begin
      if (qStd.size() == 0) begin
        checkOutput("std stray byte, queue size", 32'(qStd.size()), 32'd1);
      end else begin
        e = qStd.pop_front();
        checkOutput("std data", {24'd0, dData}, {24'd0, e.data});
        checkOutput("std last", {31'd0, dLast}, {31'd0, e.last});
        if (e.last) checkOutput("std good", {31'd0, dGood}, {31'd0, e.good});
      end
    end
  end

  task automatic driveByte(input logic [7:0] b, input logic e);
    @(negedge clk);
    rxd = b;
    dv  = 1'b1;
    er  = e;
  endtask

  task automatic driveIdle(input int n, input logic e);
    repeat (n) begin
      @(negedge clk);
      rxd = 8'h00;
      dv  = 1'b0;
      er  = e;
    end
  endtask

  function automatic logic [31:0] refFcs();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (frame[i]) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ frame[i][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  task automatic loadKnownFrame(input logic [7:0] fcs0);
    frame = {};
    for (int i = 0; i < 9; i++) frame.push_back(8'h31 + 8'(i));
    frame.push_back(fcs0);
    frame.push_back(8'h39);
    frame.push_back(8'hF4);
    frame.push_back(8'hCB);
  endtask

  task automatic loadCrcFrame(input int payloadLen);
    logic [31:0] fcs;
    frame = {};
    for (int i = 0; i < payloadLen; i++) frame.push_back(8'($urandom_range(0, 255)));
    fcs = refFcs();
    for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
  endtask

  // Queues the expected outcome for frame[] (both instances), then sends preamble, SFD, frame[] and a gap
  task automatic applyStimulus(input logic fcsOk, input int erIdx, input int gap);
    int   n;
    int   nOut;
    logic gS, gD;
    exp_t e;
    n  = frame.size();
    gS = fcsOk && (erIdx < 0) && (n >= 13);
    gD = fcsOk && (erIdx < 0) && (n >= 64);
    if (n > 1522) begin
      nOut = 1518;
      gS = 1'b0;
      gD = 1'b0;
      expDropS++;
      expDropD++;
    end else if (n < 5) begin
      nOut = 0;
      expDropS++;
      expDropD++;
    end else begin
      nOut = n - 4;
      if (gS) expGoodS++; else expBadS++;
      if (gD) expGoodD++; else expBadD++;
    end
    for (int i = 0; i < nOut; i++) begin
      e.data = frame[i];
      e.last = (i == nOut - 1);
      e.good = gS;
      qShort.push_back(e);
      e.good = gD;
      qStd.push_back(e);
    end
    repeat (7) driveByte(8'h55, 1'b0);
    driveByte(8'hD5, 1'b0);
    for (int i = 0; i < n; i++) driveByte(frame[i], (i == erIdx));
    driveIdle(gap, 1'b0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " short cnt_good"}, sCntGood, 32'(expGoodS));
    checkOutput({tag, " short cnt_bad"},  sCntBad,  32'(expBadS));
    checkOutput({tag, " short cnt_drop"}, sCntDrop, 32'(expDropS));
    checkOutput({tag, " std cnt_good"},   dCntGood, 32'(expGoodD));
    checkOutput({tag, " std cnt_bad"},    dCntBad,  32'(expBadD));
    checkOutput({tag, " std cnt_drop"},   dCntDrop, 32'(expDropD));
  endtask

  initial begin
    rstn = 1'b0;
    rxd  = 8'h00;
    dv   = 1'b0;
    er   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset rx_valid", {31'd0, sValid}, 32'd0);
    checkOutput("reset rx_last",  {31'd0, sLast},  32'd0);
    checkOutput("reset rx_good",  {31'd0, sGood},  32'd0);
    checkOutput("reset rx_data",  {24'd0, sData},  32'd0);
    checkCounters("reset");
    rstn = 1'b1;
    driveIdle(2, 1'b0);

    loadKnownFrame(8'h26);
    applyStimulus(1'b1, -1, 3);
    checkCounters("known frame");

    loadKnownFrame(8'h27);
    applyStimulus(1'b0, -1, 3);
    checkCounters("bad fcs");

    loadKnownFrame(8'h26);
    applyStimulus(1'b1, 3, 3);
    checkCounters("rx_er in payload");

    driveIdle(4, 1'b1);
    driveIdle(2, 1'b0);
    checkCounters("false carrier");

    loadCrcFrame(60);
    applyStimulus(1'b1, -1, 3);
    checkCounters("64-byte frame");

    loadCrcFrame(59);
    applyStimulus(1'b1, -1, 3);
    checkCounters("63-byte frame");

    driveByte(8'h55, 1'b0);
    driveByte(8'h55, 1'b0);
    driveByte(8'h5D, 1'b0);
    driveByte(8'h55, 1'b0);
    driveByte(8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) driveByte(8'h40 + 8'(i), 1'b0);
    driveIdle(3, 1'b0);
    expDropS++;
    expDropD++;
    checkCounters("bad preamble");

    frame = {};
    for (int i = 0; i < 4; i++) frame.push_back(8'hA0 + 8'(i));
    applyStimulus(1'b1, -1, 3);
    checkCounters("runt");

    frame = {};
    for (int i = 0; i < 1600; i++) frame.push_back(8'(i));
    applyStimulus(1'b0, -1, 3);
    checkCounters("oversize");

    checkOutput("pending short before reset", 32'(qShort.size()), 32'd0);
    checkOutput("pending std before reset",   32'(qStd.size()),   32'd0);
    qShort = {};
    qStd   = {};

    // Reset lands mid-payload and releases while dv is still high
    loadKnownFrame(8'h26);
    repeat (7) driveByte(8'h55, 1'b0);
    driveByte(8'hD5, 1'b0);
    for (int i = 0; i < 3; i++) driveByte(frame[i], 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    rxd  = frame[3];
    @(negedge clk);
    rxd = frame[4];
    checkOutput("mid-frame reset rx_valid", {31'd0, sValid}, 32'd0);
    expGoodS = 0; expBadS = 0; expDropS = 0;
    expGoodD = 0; expBadD = 0; expDropD = 0;
    checkCounters("mid-frame reset");
    @(negedge clk);
    rstn = 1'b1;
    rxd  = frame[5];
    for (int i = 6; i < 13; i++) driveByte(frame[i], 1'b0);
    driveIdle(3, 1'b0);
    checkCounters("after reset release");

    loadKnownFrame(8'h26);
    applyStimulus(1'b1, -1, 1);
    applyStimulus(1'b1, -1, 4);
    checkCounters("back-to-back");

    driveIdle(10, 1'b0);
    checkOutput("leftover short bytes", 32'(qShort.size()), 32'd0);
    checkOutput("leftover std bytes",   32'(qStd.size()),   32'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/gmii_rx_deframer.md
# gmii_rx_deframer

Receive-side framing stage that sits between the GMII receive pins (`gmii_rx_rxd_i`/`gmii_rx_rx_dv_i`/`gmii_rx_rx_er_i`) and the MAC receive datapath inside mkFTop. It strips preamble and SFD and withholds the 4-byte FCS. It checks CRC-32, length and error symbols, and delivers payload bytes as a byte stream with end-of-frame status. It cannot backpressure the PHY; downstream must accept one byte per clock.

## Interface
- `MIN_FRAME`, 64: minimum good frame length in bytes, destination address through FCS inclusive.
- `MAX_FRAME`, 1522: maximum frame length in bytes, FCS inclusive.

Ports:
- `gmii_rx_clk`  in  1  PHY receive clock. This is the block's only clock.
- `gmii_rx_rstn`  in  1  Reset, synchronous and active-low.
- `gmii_rx_rxd_i`  in  8  GMII receive data.
- `gmii_rx_rx_dv_i`  in  1  GMII data valid.
- `gmii_rx_rx_er_i`  in  1  GMII receive error.
- `rx_data`  out  8  Payload byte.
- `rx_valid`  out  1  `rx_data` is valid this cycle.
- `rx_last`  out  1  Last payload byte of the frame. Qualified by `rx_valid`.
- `rx_good`  out  1  Frame status. Meaningful only when `rx_valid & rx_last`.
- `cnt_good`  out  32  Frames delivered with `rx_good=1`. Wraps mod 2^32.
- `cnt_bad`  out  32  Frames delivered with `rx_good=0`. Wraps mod 2^32.
- `cnt_drop`  out  32  Frames not delivered: bad preamble/SFD, fewer than 5 post-SFD bytes, or oversize. Wraps mod 2^32.

## Operation
- FSM states: IDLE, PRE, DATA, DROP.
- **IDLE**
  - dv=1 and rxd=0x55: go to PRE.
  - dv=1 and rxd=0xD5: go to DATA (zero-length preamble is accepted).
  - dv=1 with any other byte: go to DROP and increment `cnt_drop`.
- **PRE**
  - rxd=0x55: stay in PRE.
  - rxd=0xD5: go to DATA.
  - Any other byte, or dv=0: go to DROP (or IDLE if dv=0) and increment `cnt_drop`.
- **DATA, on each byte with dv=1**
  - Shift the byte into a 5-entry delay line `sr[0..4]`.
  - Update CRC-32: IEEE 802.3, reflected, init 0xFFFFFFFF.
  - Increment the 11-bit length counter `len`.
  - Latch `err` if rx_er=1.
  - If the delay line already held 5 bytes before the shift, emit `sr[4]` with `rx_last=0`.
- **DATA, dv falls (dv=0 sampled)**
  - Delay line holds 5 bytes: emit `sr[4]` with `rx_last=1`, where `rx_good = (crc_reg==0xDEBB20E3) & !err & (len>=MIN_FRAME)`. Increment `cnt_good` or `cnt_bad` accordingly. Go to IDLE.
  - Delay line holds fewer than 5 bytes: emit nothing, increment `cnt_drop`, go to IDLE.
- **Oversize:** in DATA, when `len` would become `MAX_FRAME+1`, emit `sr[4]` with `rx_last=1, rx_good=0`, increment `cnt_drop` (not `cnt_bad`), and go to DROP.
  - If fewer than 5 bytes are held at that point, emit nothing.
- **DROP:** stay until dv=0, then go to IDLE.
- `rx_er` while dv=0 (carrier extension / false carrier) is ignored.
- The CRC register, `len`, `err` and the delay-line occupancy are cleared on every entry to DATA.

## Timing
- Inputs are sampled on the rising edge of `gmii_rx_clk`. All outputs are registered.
- Payload latency:
  - Payload byte k appears on `rx_data` the cycle after the edge that samples byte k+5.
  - The last payload byte appears the cycle after the edge that samples dv=0.
- `rx_valid` is a single-cycle pulse per byte. No gaps occur inside a frame while dv is held high.
- Back-to-back frames separated by one dv=0 cycle are fully supported.
  - The last byte of frame N is emitted in the same cycle that frame N+1's first preamble byte is sampled.
- Counters update in the same cycle the corresponding `rx_last` (or drop decision) is registered.
- **Reset** (`gmii_rx_rstn=0` at an edge):
  - `rx_valid`, `rx_last`, `rx_good` and `rx_data` become 0. All counters become 0.
  - The FSM enters DROP, so a frame in progress at reset release is discarded until dv=0. No partial frame is ever emitted, and the discarded frame is not counted.

## Test plan
- **Good short frame:** `MIN_FRAME=13`. Send 7×0x55, 0xD5, "123456789" (0x31..0x39), then FCS 0x26 0x39 0xF4 0xCB, then dv=0.
  - Expect 9 `rx_valid` bytes 0x31..0x39.
  - `rx_last` and `rx_good=1` on 0x39, one cycle after dv falls.
  - `cnt_good=1`.
- **Same frame, default `MIN_FRAME=64`:** expect the same 9 bytes, `rx_good=0`, `cnt_bad=1`.
- **CRC and error symbol:** same frame with the FCS first byte changed to 0x27 -> `rx_good=0`. Separately, rx_er=1 on payload byte 3 -> `rx_good=0`, and all 9 bytes are still delivered.
- **Bad preamble and runt:**
  - Preamble 0x55,0x55,0x5D -> no output, `cnt_drop=1`, no recovery until dv=0.
  - SFD followed by 4 bytes then dv=0 -> no output, `cnt_drop=2`.
- **Oversize:** 1600 post-SFD bytes of incrementing data.
  - Expect 1518 bytes delivered (`MAX_FRAME` minus the 4 held back).
  - `rx_last` with `rx_good=0` on the 1518th byte.
  - `cnt_drop=1`; remaining bytes are ignored.
- **Reset and back-to-back:**
  - Assert reset mid-payload, release while dv=1 -> no output until the next frame.
  - Then send two good 13-byte frames (`MIN_FRAME=13`) separated by one dv=0 cycle -> 18 bytes, two `rx_last`s, `cnt_good=2`.
